// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer: queues qualifying perceptron training requests and
// serialises each into one read-modify-write per weight column of the shared table.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_req_*           training request from EX (valid/ready handshake)
//   o_req_ready       FIFO not full
//   i_lookup_busy     fetch owns the table read port this cycle
//   o_tbl_rd_*        table read port, i_tbl_rd_data returns one cycle later
//   o_tbl_wr_*        table write port, never blocked
//   o_busy            FSM active or requests pending
//   o_train_cnt       trainings completed (wraps)
//   o_skip_cnt        requests accepted but not trained (wraps)
module perceptron_train_sequencer #(
    parameter int HIST_LEN   = 62,
    parameter int WIDTH      = 8,
    parameter int INDEX      = 6,
    parameter int SUM_W      = 16,
    parameter int THETA      = 134,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(HIST_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [INDEX-1:0]    i_req_idx,
    input  logic [HIST_LEN-1:0] i_req_hist,
    input  logic                i_req_taken,
    input  logic                i_req_pred,
    input  logic [SUM_W-1:0]    i_req_sum,
    input  logic                i_lookup_busy,
    output logic                o_tbl_rd_en,
    output logic [INDEX-1:0]    o_tbl_rd_row,
    output logic [CW-1:0]       o_tbl_rd_col,
    input  logic [WIDTH-1:0]    i_tbl_rd_data,
    output logic                o_tbl_wr_en,
    output logic [INDEX-1:0]    o_tbl_wr_row,
    output logic [CW-1:0]       o_tbl_wr_col,
    output logic [WIDTH-1:0]    o_tbl_wr_data,
    output logic                o_busy,
    output logic [15:0]         o_train_cnt,
    output logic [15:0]         o_skip_cnt
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state, w_next;
    logic [INDEX-1:0]    r_q_idx  [FIFO_DEPTH];
    logic [HIST_LEN-1:0] r_q_hist [FIFO_DEPTH];
    logic                r_q_tkn  [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [CNTW-1:0]     r_count;
    logic [INDEX-1:0]    r_idx;
    logic [HIST_LEN-1:0] r_hist;
    logic                r_taken;
    logic [CW-1:0]       r_col;
    logic                r_wr_en, r_wr_inc;
    logic [INDEX-1:0]    r_wr_row;
    logic [CW-1:0]       r_wr_col;
    logic [15:0]         r_train_cnt, r_skip_cnt;

    logic [SUM_W:0]      w_sext, w_mag;
    logic                w_train, w_accept, w_push, w_skip, w_pop, w_rd_en, w_inc;
    logic [HIST_LEN:0]   w_hx;
    logic [WIDTH:0]      w_wsum;
    logic [WIDTH-1:0]    w_sat;

    // Magnitude in SUM_W+1 bits so the most negative sum stays exact
    assign w_sext   = {i_req_sum[SUM_W-1], i_req_sum};
    assign w_mag    = w_sext[SUM_W] ? -w_sext : w_sext;
    assign w_train  = (i_req_taken != i_req_pred) || (w_mag <= (SUM_W+1)'(THETA));
    assign w_accept = i_req_valid && o_req_ready;
    assign w_push   = w_accept && w_train;
    assign w_skip   = w_accept && !w_train;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wptr]  <= i_req_idx;
            r_q_hist[r_wptr] <= i_req_hist;
            r_q_tkn[r_wptr]  <= i_req_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop  = r_count != '0;
                w_next = w_pop ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_rd_en = !i_lookup_busy;
                w_next  = (w_rd_en && r_col == CW'(HIST_LEN)) ? S_DRAIN : S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_hist  <= '0;
            r_taken <= 1'b0;
            r_col   <= '0;
        end else if (w_pop) begin
            r_idx   <= r_q_idx[r_rptr];
            r_hist  <= r_q_hist[r_rptr];
            r_taken <= r_q_tkn[r_rptr];
            r_col   <= '0;
        end else if (w_rd_en) begin
            r_col <= r_col + CW'(1);
        end
    end

    // Column 0 is the bias: compare taken against a constant 1 so it steps toward the outcome
    assign w_hx  = {r_hist, 1'b1};
    assign w_inc = r_taken == w_hx[r_col];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en  <= 1'b0;
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_wr_inc <= 1'b0;
        end else begin
            r_wr_en <= w_rd_en;
            if (w_rd_en) begin
                r_wr_row <= r_idx;
                r_wr_col <= r_col;
                r_wr_inc <= w_inc;
            end
        end
    end

    // A +/-1 step can only overflow by one, visible as the top two sum bits disagreeing
    assign w_wsum = {i_tbl_rd_data[WIDTH-1], i_tbl_rd_data} +
                    (r_wr_inc ? (WIDTH+1)'(1) : {(WIDTH+1){1'b1}});
    assign w_sat  = (w_wsum[WIDTH] != w_wsum[WIDTH-1]) ?
                    {w_wsum[WIDTH], {(WIDTH-1){!w_wsum[WIDTH]}}} : w_wsum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_train_cnt <= '0;
            r_skip_cnt  <= '0;
        end else begin
            if (r_state == S_DRAIN) r_train_cnt <= r_train_cnt + 16'd1;
            if (w_skip) r_skip_cnt <= r_skip_cnt + 16'd1;
        end
    end

    assign o_req_ready   = r_count != CNTW'(FIFO_DEPTH);
    assign o_tbl_rd_en   = w_rd_en;
    assign o_tbl_rd_row  = r_idx;
    assign o_tbl_rd_col  = r_col;
    assign o_tbl_wr_en   = r_wr_en;
    assign o_tbl_wr_row  = r_wr_row;
    assign o_tbl_wr_col  = r_wr_col;
    assign o_tbl_wr_data = r_wr_en ? w_sat : '0;
    assign o_busy        = (r_state != S_IDLE) || (r_count != '0);
    assign o_train_cnt   = r_train_cnt;
    assign o_skip_cnt    = r_skip_cnt;
endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// tb_perceptron_train_sequencer: directed self-checking bench with a weight-table model.
module tb_perceptron_train_sequencer;
    localparam int HL = 62;
    localparam int NC = HL + 1;

    typedef struct {
        logic [5:0]         idx;
        logic [HL-1:0]      hist;
        logic               taken;
        logic               pred;
        logic signed [15:0] sum;
        logic signed [7:0]  init;
        logic               exp_train;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [5:0]  req_idx = '0;
    logic [HL-1:0] req_hist = '0;
    logic        req_taken = 1'b0, req_pred = 1'b0;
    logic [15:0] req_sum = '0;
    logic        lookup_busy = 1'b0;
    logic        rd_en, wr_en, busy;
    logic [5:0]  rd_row, wr_row, rd_col, wr_col;
    logic [7:0]  rd_data = '0, wr_data;
    logic [15:0] train_cnt, skip_cnt;

    logic        pl_en = 1'b0;
    logic [5:0]  pl_row = '0;
    logic [7:0]  pl_val = '0;
    logic signed [7:0] mem [0:64*NC-1];

    int tests = 0, fails = 0;
    int bc = 0, rdn = 0, wrn = 0, haz = 0, lbv = 0, nrdy = 0;
    int wq[$];

    always #5 clk = ~clk;

    perceptron_train_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_idx(req_idx), .i_req_hist(req_hist),
        .i_req_taken(req_taken), .i_req_pred(req_pred), .i_req_sum(req_sum),
        .i_lookup_busy(lookup_busy),
        .o_tbl_rd_en(rd_en), .o_tbl_rd_row(rd_row), .o_tbl_rd_col(rd_col),
        .i_tbl_rd_data(rd_data),
        .o_tbl_wr_en(wr_en), .o_tbl_wr_row(wr_row), .o_tbl_wr_col(wr_col),
        .o_tbl_wr_data(wr_data),
        .o_busy(busy), .o_train_cnt(train_cnt), .o_skip_cnt(skip_cnt)
    );

    function automatic int addr(input logic [5:0] r, input int c);
        return int'(r) * NC + c;
    endfunction

    always @(posedge clk) begin
        if (pl_en) for (int c = 0; c < NC; c++) mem[addr(pl_row, c)] <= pl_val;
        if (rd_en) rd_data <= mem[addr(rd_row, int'(rd_col))];
        if (wr_en) mem[addr(wr_row, int'(wr_col))] <= wr_data;
    end

    always @(negedge clk) begin
        if (busy) bc++;
        if (rd_en) rdn++;
        if (wr_en) wrn++;
        if (rd_en && wr_en && rd_row == wr_row && rd_col == wr_col) haz++;
        if (rd_en && lookup_busy) lbv++;
        if (wr_en && wr_col == 6'd0) wq.push_back(int'(wr_row));
        if (req_valid && !req_ready) nrdy++;
    end

    task automatic chk(input string n, input longint a, input longint e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic logic signed [7:0] step(input logic signed [7:0] w, input logic t,
                                               input logic [HL-1:0] h, input int c);
        int d, s;
        d = (c == 0) ? (t ? 1 : -1) : ((t == h[c-1]) ? 1 : -1);
        s = int'(w) + d;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    task automatic check_row(input string n, input logic [5:0] r, input logic signed [7:0] init,
                             input logic t, input logic [HL-1:0] h, input int ncols, input int times);
        int bad = 0, fc = -1;
        logic signed [7:0] e, g, fe, fg;
        fe = '0;
        fg = '0;
        for (int c = 0; c < NC; c++) begin
            e = init;
            if (c < ncols) repeat (times) e = step(e, t, h, c);
            g = mem[addr(r, c)];
            if (g !== e) begin
                bad++;
                if (fc < 0) begin fc = c; fe = e; fg = g; end
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s row %0d: %0d bad cols, first col %0d got %0d expected %0d",
                     n, r, bad, fc, fg, fe);
        end
    endtask

    task automatic preload(input logic [5:0] r, input logic [7:0] v);
        pl_row = r;
        pl_val = v;
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int k = 0;
        req_idx = v.idx;
        req_hist = v.hist;
        req_taken = v.taken;
        req_pred = v.pred;
        req_sum = v.sum;
        req_valid = 1'b1;
        while (!req_ready && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) chk("send_timeout", k, 0);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin @(negedge clk); k++; end
        if (k >= 2000) chk("idle_timeout", k, 0);
        @(negedge clk);
    endtask

    task automatic wait_col(input int c, input string n);
        int k = 0;
        while (!(rd_en && int'(rd_col) == c) && k < 300) begin @(negedge clk); k++; end
        chk(n, int'(rd_en && int'(rd_col) == c), 1);
    endtask

    vec_t vt[9];
    vec_t v;
    int t0, s0, b0, w0, r0, l0, q0, n0;

    initial begin
        vt[0] = '{6'd5, 62'h1, 1'b1, 1'b0, 16'sd300, 8'sd3, 1'b1};
        vt[1] = '{6'd6, 62'h0, 1'b1, 1'b1, 16'sd135, 8'sd0, 1'b0};
        vt[2] = '{6'd7, {HL{1'b1}}, 1'b1, 1'b1, -16'sd134, 8'sd0, 1'b1};
        vt[3] = '{6'd8, 62'h0, 1'b1, 1'b1, 16'sh8000, 8'sd0, 1'b0};
        vt[4] = '{6'd9, 62'h1555_5555_5555_5555, 1'b0, 1'b0, 16'sd134, -8'sd5, 1'b1};
        vt[5] = '{6'd1, {HL{1'b1}}, 1'b1, 1'b1, 16'sd0, 8'sd127, 1'b1};
        vt[6] = '{6'd2, {HL{1'b1}}, 1'b0, 1'b0, 16'sd0, 8'sh80, 1'b1};
        vt[7] = '{6'd3, 62'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, -16'sd135, 8'sd0, 1'b1};
        vt[8] = '{6'd4, 62'h0, 1'b0, 1'b0, -16'sd135, 8'sd0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_train_cnt", train_cnt, 0);
        chk("rst_skip_cnt", skip_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            preload(vt[i].idx, vt[i].init);
            t0 = int'(train_cnt); s0 = int'(skip_cnt); b0 = bc; w0 = wrn; r0 = rdn;
            send(vt[i]);
            req_valid = 1'b0;
            wait_idle();
            chk($sformatf("v%0d_train_cnt", i), int'(train_cnt) - t0, vt[i].exp_train);
            chk($sformatf("v%0d_skip_cnt", i), int'(skip_cnt) - s0, !vt[i].exp_train);
            chk($sformatf("v%0d_reads", i), rdn - r0, vt[i].exp_train ? NC : 0);
            chk($sformatf("v%0d_writes", i), wrn - w0, vt[i].exp_train ? NC : 0);
            chk($sformatf("v%0d_busy_cycles", i), bc - b0, vt[i].exp_train ? HL + 3 : 0);
            check_row($sformatf("v%0d_row", i), vt[i].idx, vt[i].init, vt[i].taken, vt[i].hist,
                      vt[i].exp_train ? NC : 0, 1);
        end
        chk("mispred_col0", mem[addr(6'd5, 0)], 4);
        chk("mispred_col1", mem[addr(6'd5, 1)], 4);
        chk("mispred_col2", mem[addr(6'd5, 2)], 2);

        v = '{6'd30, 62'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 16'sd0, 8'sd10, 1'b1};
        preload(v.idx, v.init);
        b0 = bc; r0 = rdn; l0 = lbv;
        send(v);
        req_valid = 1'b0;
        wait_col(20, "arb_reach_col20");
        chk("arb_wr19_en", wr_en, 1);
        chk("arb_wr19_col", wr_col, 19);
        lookup_busy = 1'b1;
        #1 chk("arb_rd_blocked", rd_en, 0);
        repeat (10) @(negedge clk);
        lookup_busy = 1'b0;
        #1;
        chk("arb_resume_en", rd_en, 1);
        chk("arb_resume_col", rd_col, 20);
        wait_idle();
        chk("arb_no_rd_while_busy", lbv - l0, 0);
        chk("arb_reads", rdn - r0, NC);
        chk("arb_busy_cycles", bc - b0, 75);
        check_row("arb_row", v.idx, v.init, v.taken, v.hist, NC, 1);

        v = '{6'd40, 62'h3, 1'b0, 1'b1, 16'sd0, 8'sd0, 1'b1};
        preload(6'd40, 8'd0);
        preload(6'd41, 8'd0);
        preload(6'd42, 8'd0);
        t0 = int'(train_cnt); q0 = wq.size(); n0 = nrdy;
        for (int i = 0; i < 6; i++) begin
            v.idx = 6'(40 + i / 2);
            send(v);
        end
        req_valid = 1'b0;
        wait_idle();
        chk("bp_ready_dropped", int'(nrdy > n0), 1);
        chk("bp_train_cnt", int'(train_cnt) - t0, 6);
        chk("bp_order_len", wq.size() - q0, 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("bp_order%0d", j), (q0 + j < wq.size()) ? wq[q0 + j] : -1, 40 + j / 2);
        for (int r = 40; r < 43; r++)
            check_row("bp_row", 6'(r), 8'sd0, v.taken, v.hist, NC, 2);

        v = '{6'd50, 62'h2AAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 16'sd0, 8'sd5, 1'b1};
        preload(v.idx, v.init);
        send(v);
        req_valid = 1'b0;
        wait_col(30, "rst_reach_col30");
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_rd_en", rd_en, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 1);
        chk("mrst_train_cnt", train_cnt, 0);
        chk("mrst_skip_cnt", skip_cnt, 0);
        rst_n = 1'b1;
        w0 = wrn;
        repeat (20) @(negedge clk);
        chk("mrst_no_writes", wrn - w0, 0);
        chk("mrst_idle", busy, 0);
        check_row("mrst_row", v.idx, v.init, v.taken, v.hist, 30, 1);
        chk("rw_same_col_hazard", haz, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
